// File: rtl/bin_word_deserializer.sv
// Serial MSB-first bit collector framing WIDTH-bit words
// into a small output FIFO with sticky fault flags.
module bin_word_deserializer #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ser_in,
  input  logic                       ser_valid,
  input  logic                       ser_first,
  input  logic                       clr_flags,
  output logic [WIDTH-1:0]           word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       frame_err,
  output logic                       overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             push, ferr_set;
  logic [WIDTH-1:0] push_word;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic             pop, full, wr_en, ovf_set;

  assign push_word = {sreg[WIDTH-2:0], ser_in};

  // Collector state, bit count and shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sreg  <= sreg_n;
    end
  end

  // Framing decisions: restart on ser_first, push on last bit
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    sreg_n   = sreg;
    push     = 1'b0;
    ferr_set = 1'b0;
    if (ser_valid) begin
      unique case (state)
        IDLE: begin
          if (ser_first) begin
            sreg_n  = {{(WIDTH-1){1'b0}}, ser_in};
            cnt_n   = CW'(1);
            state_n = COLLECT;
          end else begin
            ferr_set = 1'b1;
          end
        end
        COLLECT: begin
          if (ser_first) begin
            ferr_set = 1'b1;
            sreg_n   = {{(WIDTH-1){1'b0}}, ser_in};
            cnt_n    = CW'(1);
          end else begin
            sreg_n = push_word;
            if (cnt == LAST) begin
              push    = 1'b1;
              cnt_n   = '0;
              state_n = IDLE;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign word_valid = (level != '0);
  assign full       = (level == FULL);
  assign pop        = word_valid & word_ready;
  assign wr_en      = push & (~full | pop);
  assign ovf_set    = push & full & ~pop;
  assign word_out   = word_valid ? mem[rptr] : '0;

  // FIFO storage; contents beyond level are don't-care
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wptr] <= push_word;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_en)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
      if (wr_en && !pop)
        level <= level + LW'(1);
      else if (pop && !wr_en)
        level <= level - LW'(1);
    end
  end

  // Sticky flags; a new fault beats a same-edge clear
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= ferr_set | (frame_err & ~clr_flags);
      overflow  <= ovf_set | (overflow & ~clr_flags);
    end
  end

endmodule
